// File: rtl/ring_pkg.sv
// Shared types and helpers for consumers of the one-hot ring select bus.
// Helpers work on a zero-extended vector so any ring width up to RING_MAX_N can use them.
package ring_pkg;

  localparam int unsigned RING_MAX_N = 64;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } ring_state_e;

  function automatic logic is_onehot(input logic [RING_MAX_N-1:0] vec);
    return (vec != '0) && ((vec & (vec - RING_MAX_N'(1))) == '0);
  endfunction

  // n is the real ring width; bits at and above n must be zero on entry.
  function automatic logic [RING_MAX_N-1:0] rot_right(input logic [RING_MAX_N-1:0] vec,
                                                      input int unsigned         n);
    logic [RING_MAX_N-1:0] r;
    r        = vec >> 1;
    r[n-1]   = vec[0];
    return r;
  endfunction

endpackage

// File: rtl/ring_token_monitor_onehot_encoder.sv
// Combinational one-hot to binary encoder with a validity flag.
// idx is only meaningful when vec_onehot is high.
module onehot_encoder
  import ring_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 vec_onehot
);

  localparam int IDX_W = $clog2(N);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = idx | IDX_W'(i);
    end
  end

  assign vec_onehot = is_onehot(RING_MAX_N'(vec));

endmodule

// File: rtl/ring_token_monitor.sv
// Watches the one-hot ring select bus: encodes the token position, tracks lock
// on right-rotating advance, counts laps and flags protocol errors.
module ring_token_monitor
  import ring_pkg::*;
#(
  parameter int N     = 3,
  parameter int LAP_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [N-1:0]         in_vec,
  input  logic                 clear_err,
  output logic [$clog2(N)-1:0] idx_out,
  output logic                 idx_valid,
  output logic                 locked,
  output logic                 lap_done,
  output logic [LAP_W-1:0]     lap_count,
  output logic                 err_onehot,
  output logic                 err_seq,
  output logic                 err_sticky
);

  localparam int IDX_W = $clog2(N);

  ring_state_e      state_q, state_d;
  logic             have_prev_q, have_prev_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             lap_done_q, lap_done_d;
  logic [LAP_W-1:0] lap_count_q, lap_count_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_seq_q, err_seq_d;
  logic             err_sticky_q, err_sticky_d;

  logic [IDX_W-1:0] enc_idx;
  logic             vec_onehot;
  logic [N-1:0]     rot_prev;
  logic             is_succ;

  onehot_encoder #(.N(N)) u_enc (
    .vec        (in_vec),
    .idx        (enc_idx),
    .vec_onehot (vec_onehot)
  );

  assign rot_prev = N'(rot_right(RING_MAX_N'(prev_q), N));
  assign is_succ  = have_prev_q && (in_vec == rot_prev);

  always_comb begin
    state_d      = state_q;
    have_prev_d  = have_prev_q;
    prev_d       = prev_q;
    idx_d        = idx_q;
    idx_valid_d  = 1'b0;
    lap_done_d   = 1'b0;
    lap_count_d  = lap_count_q;
    err_onehot_d = 1'b0;
    err_seq_d    = 1'b0;

    if (in_valid) begin
      if (!vec_onehot) begin
        err_onehot_d = 1'b1;
        have_prev_d  = 1'b0;
        state_d      = ACQUIRE;
      end else begin
        idx_d       = enc_idx;
        idx_valid_d = 1'b1;
        prev_d      = in_vec;
        have_prev_d = 1'b1;
        if (state_q == ACQUIRE) begin
          if (is_succ) state_d = LOCKED;
        end else if (is_succ) begin
          // Token leaving bit 0 wraps to bit N-1: one lap complete.
          if (prev_q[0]) begin
            lap_done_d  = 1'b1;
            lap_count_d = lap_count_q + LAP_W'(1);
          end
        end else begin
          err_seq_d = 1'b1;
          state_d   = ACQUIRE;
        end
      end
    end

    if (err_onehot_d || err_seq_d) err_sticky_d = 1'b1;
    else if (clear_err)            err_sticky_d = 1'b0;
    else                           err_sticky_d = err_sticky_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACQUIRE;
      have_prev_q  <= 1'b0;
      prev_q       <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      lap_done_q   <= 1'b0;
      lap_count_q  <= '0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      have_prev_q  <= have_prev_d;
      prev_q       <= prev_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      lap_done_q   <= lap_done_d;
      lap_count_q  <= lap_count_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign idx_out    = idx_q;
  assign idx_valid  = idx_valid_q;
  assign locked     = (state_q == LOCKED);
  assign lap_done   = lap_done_q;
  assign lap_count  = lap_count_q;
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_ring_token_monitor.sv
// Directed bench for ring_token_monitor with N=3; a second instance with LAP_W=2
// shares the stimulus to observe lap counter wrap.
module tb_ring_token_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_vec;
  logic       clear_err;

  logic [1:0] idx_out, idx_out2;
  logic       idx_valid, idx_valid2;
  logic       locked, locked2;
  logic       lap_done, lap_done2;
  logic [7:0] lap_count;
  logic [1:0] lap_count2;
  logic       err_onehot, err_onehot2;
  logic       err_seq, err_seq2;
  logic       err_sticky, err_sticky2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_token_monitor #(.N(3), .LAP_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_vec(in_vec), .clear_err(clear_err),
    .idx_out(idx_out), .idx_valid(idx_valid), .locked(locked), .lap_done(lap_done),
    .lap_count(lap_count), .err_onehot(err_onehot), .err_seq(err_seq), .err_sticky(err_sticky)
  );

  ring_token_monitor #(.N(3), .LAP_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_vec(in_vec), .clear_err(clear_err),
    .idx_out(idx_out2), .idx_valid(idx_valid2), .locked(locked2), .lap_done(lap_done2),
    .lap_count(lap_count2), .err_onehot(err_onehot2), .err_seq(err_seq2), .err_sticky(err_sticky2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected: idx, idx_valid, locked, lap_done, lap_count, err_onehot, err_seq, err_sticky
  task automatic chk_out(input string tag, input int e_idx, input int e_iv, input int e_lk,
                         input int e_ld, input int e_lc, input int e_eo, input int e_es,
                         input int e_st);
    chk({tag, ".idx_out"},    32'(idx_out),    e_idx);
    chk({tag, ".idx_valid"},  32'(idx_valid),  e_iv);
    chk({tag, ".locked"},     32'(locked),     e_lk);
    chk({tag, ".lap_done"},   32'(lap_done),   e_ld);
    chk({tag, ".lap_count"},  32'(lap_count),  e_lc);
    chk({tag, ".err_onehot"}, 32'(err_onehot), e_eo);
    chk({tag, ".err_seq"},    32'(err_seq),    e_es);
    chk({tag, ".err_sticky"}, 32'(err_sticky), e_st);
  endtask

  task automatic cyc(input logic v, input logic [2:0] vec, input logic clr);
    in_valid  = v;
    in_vec    = vec;
    clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 3'b000, 1'b0);
    reset = 1'b0;
  endtask

  // Lock-and-lap sequence 001,100,010,001,100 with optional idle gaps.
  task automatic run_seq(input string tag, input int gap);
    logic [2:0] vecs [5];
    int         e_idx[5];
    int         e_lk [5];
    int         e_ld [5];
    int         e_lc [5];
    vecs  = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b100};
    e_idx = '{0, 2, 1, 0, 2};
    e_lk  = '{0, 1, 1, 1, 1};
    e_ld  = '{0, 0, 0, 0, 1};
    e_lc  = '{0, 0, 0, 0, 1};
    for (int s = 0; s < 5; s++) begin
      cyc(1'b1, vecs[s], 1'b0);
      chk_out($sformatf("%s.s%0d", tag, s + 1), e_idx[s], 1, e_lk[s], e_ld[s], e_lc[s], 0, 0, 0);
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, 3'b111, 1'b0);
        chk_out($sformatf("%s.s%0d.gap%0d", tag, s + 1, g), e_idx[s], 0, e_lk[s], 0, e_lc[s], 0, 0, 0);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 3'b011;
    clear_err = 1'b0;
    @(posedge clk); #1;
    chk_out("rst.c1", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("rst.c2", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(1'b0, 3'b011, 1'b0);
    chk_out("rst.after", 0, 0, 0, 0, 0, 0, 0, 0);

    run_seq("lap", 0);

    do_reset();
    run_seq("gap", 3);

    // Locked with prev=100, lap_count=1
    cyc(1'b1, 3'b011, 1'b0);
    chk_out("noh.011", 2, 0, 0, 0, 1, 1, 0, 1);
    cyc(1'b1, 3'b010, 1'b0);
    chk_out("noh.010", 1, 1, 0, 0, 1, 0, 0, 1);
    cyc(1'b1, 3'b001, 1'b0);
    chk_out("noh.001", 0, 1, 1, 0, 1, 0, 0, 1);
    cyc(1'b0, 3'b000, 1'b1);
    chk_out("noh.clr", 0, 0, 1, 0, 1, 0, 0, 0);

    do_reset();
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b1, 3'b100, 1'b0);
    cyc(1'b1, 3'b010, 1'b0);
    chk_out("skip.pre", 1, 1, 1, 0, 0, 0, 0, 0);
    cyc(1'b1, 3'b100, 1'b0);
    chk_out("skip.100", 2, 1, 0, 0, 0, 0, 1, 1);
    cyc(1'b1, 3'b010, 1'b0);
    chk_out("skip.relock", 1, 1, 1, 0, 0, 0, 0, 1);
    cyc(1'b1, 3'b000, 1'b0);
    chk_out("skip.000", 1, 0, 0, 0, 0, 1, 0, 1);

    cyc(1'b0, 3'b000, 1'b1);
    chk_out("clr.first", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b1, 3'b100, 1'b0);
    chk_out("clr.lock", 2, 1, 1, 0, 0, 0, 0, 0);
    cyc(1'b1, 3'b001, 1'b1);
    chk_out("clr.with_err", 0, 1, 0, 0, 0, 0, 1, 1);
    cyc(1'b0, 3'b000, 1'b1);
    chk_out("clr.alone", 0, 0, 0, 0, 0, 0, 0, 0);

    do_reset();
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b1, 3'b100, 1'b0);
    chk("wrap.locked2", 32'(locked2), 1);
    begin
      int e_lc2[5];
      e_lc2 = '{1, 2, 3, 0, 1};
      for (int l = 0; l < 5; l++) begin
        cyc(1'b1, 3'b010, 1'b0);
        cyc(1'b1, 3'b001, 1'b0);
        chk($sformatf("wrap.l%0d.pre_lap_done2", l + 1), 32'(lap_done2), 0);
        cyc(1'b1, 3'b100, 1'b0);
        chk($sformatf("wrap.l%0d.lap_done2", l + 1), 32'(lap_done2), 1);
        chk($sformatf("wrap.l%0d.lap_count2", l + 1), 32'(lap_count2), e_lc2[l]);
        chk($sformatf("wrap.l%0d.lap_count", l + 1), 32'(lap_count), l + 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
